// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed biquad scheduler.
//   state_t        : scheduler FSM states
//   CFG_G1..CFG_G4 : coefficient register addresses on the cfg port
//   G*_DEFAULT     : power-on coefficient values
//   scale_product  : signed multiply, arithmetic shift right, truncate to PROD_W
package iir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL1 = 3'd1,
    ST_MUL2 = 3'd2,
    ST_MUL3 = 3'd3,
    ST_MUL4 = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  localparam logic [1:0] CFG_G1 = 2'd0;
  localparam logic [1:0] CFG_G2 = 2'd1;
  localparam logic [1:0] CFG_G3 = 2'd2;
  localparam logic [1:0] CFG_G4 = 2'd3;

  localparam int G1_DEFAULT = 511;
  localparam int G2_DEFAULT = -1764;
  localparam int G3_DEFAULT = -1412;
  localparam int G4_DEFAULT = 889;

  // Widest datapath the product helper supports; callers sign-extend
  // their operands to this width and keep only the low bits they need.
  localparam int PROD_W = 64;

  // Full-precision signed product, floor-shifted by frac bits. The low
  // PROD_W bits are returned; the shift is arithmetic so negative products
  // round toward minus infinity.
  function automatic logic signed [PROD_W-1:0] scale_product(
    input logic signed [PROD_W-1:0] a,
    input logic signed [PROD_W-1:0] b,
    input int unsigned              frac
  );
    logic signed [2*PROD_W-1:0] p;
    p = (2*PROD_W)'(a) * (2*PROD_W)'(b);
    return PROD_W'(p >>> frac);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter.
//   i_req   : per-channel request vector
//   i_ptr   : channel with highest priority this cycle
//   o_grant : one-hot grant (all zero when nothing requests)
//   o_idx   : index of the granted channel
//   o_any   : at least one request present
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_ptr,
  output logic [NCH-1:0] o_grant,
  output logic [CW-1:0]  o_idx,
  output logic           o_any
);

  logic [CW:0]   w_sum;
  logic [CW-1:0] w_idx;

  // Scan NCH positions starting at the pointer, wrapping at NCH; the first
  // requester found wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int off = 0; off < NCH; off++) begin
      w_sum = {1'b0, i_ptr} + (CW+1)'(off);
      if (w_sum >= (CW+1)'(NCH)) begin
        w_sum = w_sum - (CW+1)'(NCH);
      end
      w_idx = w_sum[CW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_idx          = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iir_channel_scheduler.sv
// One second-order IIR section shared by NCH channels through a single
// multiplier. A round-robin arbiter picks a channel in IDLE, four products
// are issued serially (m1, m2, m4, m3), the channel's delay state is written
// back and the result is held on a valid/ready output.
//   clk, reset           : clock, asynchronous active-low reset
//   in_valid/in_data     : per-channel sample requests, packed WIDTH lanes
//   in_ready             : one-hot grant, only in the grant cycle
//   out_valid/out_ready  : result handshake; out_data/out_chan held while stalled
//   cfg_we/addr/wdata    : coefficient shadow write port (0=g1 .. 3=g4)
//   busy                 : FSM not in IDLE
module iir_channel_scheduler
  import iir_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 10,
  parameter int NCH     = 4,
  parameter int G1_INIT = G1_DEFAULT,
  parameter int G2_INIT = G2_DEFAULT,
  parameter int G3_INIT = G3_DEFAULT,
  parameter int G4_INIT = G4_DEFAULT,
  localparam int CW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [WIDTH-1:0]     cfg_wdata,
  output logic                 busy
);

  state_t r_state;
  state_t w_state_next;

  logic signed [WIDTH-1:0] r_d1     [NCH];
  logic signed [WIDTH-1:0] r_d2     [NCH];
  logic signed [WIDTH-1:0] r_shadow [4];
  logic signed [WIDTH-1:0] r_active [4];
  logic                    r_cfg_dirty;

  logic [CW-1:0]           r_rr_ptr;
  logic [CW-1:0]           r_chan;
  logic signed [WIDTH-1:0] r_x;
  logic signed [WIDTH-1:0] r_cd1;
  logic signed [WIDTH-1:0] r_cd2;
  logic signed [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]        r_out_data;
  logic [CW-1:0]           r_out_chan;
  logic                    r_out_valid;

  logic signed [WIDTH-1:0] w_lane [NCH];
  logic [NCH-1:0]          w_grant;
  logic [CW-1:0]           w_grant_idx;
  logic                    w_grant_any;
  logic [CW-1:0]           w_ptr_next;

  logic signed [WIDTH-1:0]  w_mul_a;
  logic signed [WIDTH-1:0]  w_mul_b;
  logic signed [PROD_W-1:0] w_op_a;
  logic signed [PROD_W-1:0] w_op_b;
  logic signed [WIDTH-1:0]  w_prod;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      assign w_lane[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  assign w_ptr_next = (w_grant_idx == CW'(NCH-1)) ? '0 : w_grant_idx + CW'(1);

  // Operand select for the shared multiplier. Order m1, m2, m4, m3 lets w
  // complete after MUL3 so MUL4 only has to add m3 and d2.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      ST_MUL1: begin w_mul_a = r_x;   w_mul_b = r_active[CFG_G1]; end
      ST_MUL2: begin w_mul_a = r_cd1; w_mul_b = r_active[CFG_G2]; end
      ST_MUL3: begin w_mul_a = r_cd2; w_mul_b = r_active[CFG_G4]; end
      ST_MUL4: begin w_mul_a = r_cd1; w_mul_b = r_active[CFG_G3]; end
      default: begin w_mul_a = '0;    w_mul_b = '0;               end
    endcase
  end

  assign w_op_a = PROD_W'(w_mul_a);
  assign w_op_b = PROD_W'(w_mul_b);

  generate
    if (WIDTH < PROD_W) begin : g_trunc
      logic [PROD_W-WIDTH-1:0] w_prod_hi_unused;
      assign {w_prod_hi_unused, w_prod} = scale_product(w_op_a, w_op_b, FRAC);
    end else begin : g_full
      assign w_prod = scale_product(w_op_a, w_op_b, FRAC);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = '0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        // Gated by reset so no grant is visible while the block is held.
        if (reset) begin
          in_ready = w_grant;
        end
        if (w_grant_any) begin
          w_state_next = ST_MUL1;
        end
      end
      ST_MUL1: w_state_next = ST_MUL2;
      ST_MUL2: w_state_next = ST_MUL3;
      ST_MUL3: w_state_next = ST_MUL4;
      ST_MUL4: w_state_next = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        r_d1[c] <= '0;
        r_d2[c] <= '0;
      end
      r_shadow[CFG_G1] <= WIDTH'(G1_INIT);
      r_shadow[CFG_G2] <= WIDTH'(G2_INIT);
      r_shadow[CFG_G3] <= WIDTH'(G3_INIT);
      r_shadow[CFG_G4] <= WIDTH'(G4_INIT);
      r_active[CFG_G1] <= WIDTH'(G1_INIT);
      r_active[CFG_G2] <= WIDTH'(G2_INIT);
      r_active[CFG_G3] <= WIDTH'(G3_INIT);
      r_active[CFG_G4] <= WIDTH'(G4_INIT);
      r_cfg_dirty <= 1'b0;
      r_rr_ptr    <= '0;
      r_chan      <= '0;
      r_x         <= '0;
      r_cd1       <= '0;
      r_cd2       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_shadow[cfg_addr] <= cfg_wdata;
      end

      // A write landing in the same IDLE cycle as a copy keeps the flag set,
      // so the new value is picked up on the following IDLE cycle.
      if (cfg_we) begin
        r_cfg_dirty <= 1'b1;
      end else if (r_state == ST_IDLE) begin
        r_cfg_dirty <= 1'b0;
      end

      if (r_state == ST_IDLE && r_cfg_dirty) begin
        r_active <= r_shadow;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_x      <= w_lane[w_grant_idx];
            r_cd1    <= r_d1[w_grant_idx];
            r_cd2    <= r_d2[w_grant_idx];
            r_chan   <= w_grant_idx;
            r_rr_ptr <= w_ptr_next;
          end
        end
        ST_MUL1: r_acc <= w_prod;
        ST_MUL2: r_acc <= r_acc - w_prod;
        ST_MUL3: r_acc <= r_acc - w_prod;
        ST_MUL4: begin
          // r_acc holds w here; y = w + m3 + d2.
          r_d1[r_chan] <= r_acc;
          r_d2[r_chan] <= r_cd1;
          r_out_data   <= r_acc + w_prod + r_cd2;
          r_out_chan   <= r_chan;
          r_out_valid  <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_iir_channel_scheduler.sv
module tb_iir_channel_scheduler;

  localparam int WIDTH = 32;
  localparam int FRAC  = 10;
  localparam int NCH   = 4;
  localparam int CW    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CW-1:0]        out_chan;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [WIDTH-1:0]     cfg_wdata;
  logic                 busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  iir_channel_scheduler #(
    .WIDTH(WIDTH), .FRAC(FRAC), .NCH(NCH),
    .G1_INIT(511), .G2_INIT(-1764), .G3_INIT(-1412), .G4_INIT(889)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy)
  );

  // ---------------- reference model ----------------
  int m_d1 [NCH];
  int m_d2 [NCH];
  int m_sh [4];
  int m_rr;

  function automatic int scale(input int a, input int g);
    longint p;
    p = longint'(a) * longint'(g);
    return int'(p >>> FRAC);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_d1[c] = 0;
      m_d2[c] = 0;
    end
    m_sh[0] = 511; m_sh[1] = -1764; m_sh[2] = -1412; m_sh[3] = 889;
    m_rr = 0;
  endfunction

  // A sample uses the coefficients written before its grant cycle.
  function automatic int model_sample(input int c, input int x);
    int w;
    int y;
    w = scale(x, m_sh[0]) - scale(m_d1[c], m_sh[1]) - scale(m_d2[c], m_sh[3]);
    y = w + scale(m_d1[c], m_sh[2]) + m_d2[c];
    m_d2[c] = m_d1[c];
    m_d1[c] = w;
    m_rr = (c + 1) % NCH;
    return y;
  endfunction

  // ---------------- drive / wait helpers ----------------
  task automatic set_lane(input int c, input int x);
    in_data[c*WIDTH +: WIDTH] = x;
  endtask

  task automatic wait_grant(output logic [NCH-1:0] rdy, output bit ok);
    ok = 1'b0;
    rdy = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready != '0) begin
        rdy = in_ready;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the grant-cycle negedge; lat counts clock edges until out_valid.
  task automatic wait_out(input logic [NCH-1:0] drop, output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = in_valid & ~drop;
      if (out_valid) begin
        lat = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_one(input int c, input int x, output logic [NCH-1:0] rdy,
                         output int lat, output logic [WIDTH-1:0] got,
                         output logic [CW-1:0] gch, output bit ok);
    logic [NCH-1:0] m;
    m = '0;
    m[c] = 1'b1;
    got = '0;
    gch = '0;
    lat = 0;
    @(posedge clk);
    #1;
    set_lane(c, x);
    in_valid[c] = 1'b1;
    wait_grant(rdy, ok);
    if (!ok) begin
      in_valid[c] = 1'b0;
      return;
    end
    wait_out(m, lat, ok);
    if (!ok) return;
    got = out_data;
    gch = out_chan;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    in_valid = '1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== '0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got=%0d want=0", out_data); else n_pass++;
    n_checks++; if (out_chan !== '0) $display("FAIL reset_out_chan got=%0d want=0", out_chan); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    in_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [NCH-1:0] rdy; int lat; logic [WIDTH-1:0] got; logic [CW-1:0] gch; bit ok; int y;
    int xs [2];
    xs[0] = 1024;
    xs[1] = 0;
    for (int k = 0; k < 2; k++) begin
      run_one(0, xs[k], rdy, lat, got, gch, ok);
      y = model_sample(0, xs[k]);
      n_checks++; if (!ok) $display("FAIL basic_timeout got=timeout want=response"); else n_pass++;
      n_checks++; if (rdy !== 4'b0001) $display("FAIL basic_ready got=%b want=0001", rdy); else n_pass++;
      n_checks++; if (lat !== 5) $display("FAIL basic_latency got=%0d want=5", lat); else n_pass++;
      n_checks++; if (got !== WIDTH'(y)) $display("FAIL basic_data got=%0d want=%0d", $signed(got), y); else n_pass++;
      n_checks++; if (gch !== 2'd0) $display("FAIL basic_chan got=%0d want=0", gch); else n_pass++;
      $display("basic: ch=0 x=%0d y=%0d exp=%0d", xs[k], $signed(got), y);
      accept();
    end
  endtask

  task automatic test_simultaneous();
    logic [NCH-1:0] rdy; int lat; bit ok; int y; int x0;
    do_reset();
    x0 = 5000;
    @(posedge clk);
    #1;
    set_lane(0, x0);
    set_lane(2, 1024);
    in_valid = 4'b0101;
    wait_grant(rdy, ok);
    y = model_sample(0, x0);
    n_checks++; if (rdy !== 4'b0001) $display("FAIL simul_ready0 got=%b want=0001", rdy); else n_pass++;
    wait_out(4'b0001, lat, ok);
    n_checks++; if (out_data !== WIDTH'(y) || !ok) $display("FAIL simul_data0 got=%0d want=%0d", $signed(out_data), y); else n_pass++;
    n_checks++; if (out_chan !== 2'd0) $display("FAIL simul_chan0 got=%0d want=0", out_chan); else n_pass++;
    $display("simul: ch=0 x=%0d y=%0d exp=%0d", x0, $signed(out_data), y);
    accept();
    wait_grant(rdy, ok);
    y = model_sample(2, 1024);
    n_checks++; if (rdy !== 4'b0100) $display("FAIL simul_ready2 got=%b want=0100", rdy); else n_pass++;
    wait_out(4'b0100, lat, ok);
    n_checks++; if (out_data !== WIDTH'(y) || !ok) $display("FAIL simul_data2 got=%0d want=%0d", $signed(out_data), y); else n_pass++;
    n_checks++; if (out_chan !== 2'd2) $display("FAIL simul_chan2 got=%0d want=2", out_chan); else n_pass++;
    $display("simul: ch=2 x=1024 y=%0d exp=%0d", $signed(out_data), y);
    accept();
  endtask

  task automatic test_backpressure();
    logic [NCH-1:0] rdy; int lat; logic [WIDTH-1:0] got; logic [CW-1:0] gch; bit ok; int y; int x; int bad;
    x = int'($urandom_range(0, 200000)) - 100000;
    run_one(0, x, rdy, lat, got, gch, ok);
    y = model_sample(0, x);
    n_checks++; if (got !== WIDTH'(y) || !ok) $display("FAIL bp_data got=%0d want=%0d", $signed(got), y); else n_pass++;
    $display("backpressure: ch=0 x=%0d y=%0d exp=%0d", x, $signed(got), y);
    set_lane(2, 777);
    in_valid[2] = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid); else n_pass++;
      n_checks++; if (out_data !== WIDTH'(y)) $display("FAIL bp_hold_data cyc=%0d got=%0d want=%0d", i, $signed(out_data), y); else n_pass++;
      n_checks++; if (out_chan !== 2'd0) $display("FAIL bp_hold_chan cyc=%0d got=%0d want=0", i, out_chan); else n_pass++;
      n_checks++; if (in_ready !== '0) $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL bp_busy cyc=%0d got=%b want=1", i, busy); else n_pass++;
    end
    accept();
    wait_grant(rdy, ok);
    y = model_sample(2, 777);
    n_checks++; if (rdy !== 4'b0100) $display("FAIL bp_next_ready got=%b want=0100", rdy); else n_pass++;
    wait_out(4'b0100, lat, ok);
    n_checks++; if (lat !== 5) $display("FAIL bp_next_latency got=%0d want=5", lat); else n_pass++;
    n_checks++; if (out_data !== WIDTH'(y)) $display("FAIL bp_next_data got=%0d want=%0d", $signed(out_data), y); else n_pass++;
    $display("backpressure: ch=2 x=777 y=%0d exp=%0d", $signed(out_data), y);
    accept();
  endtask

  task automatic test_cfg_midflight();
    logic [NCH-1:0] rdy; int lat; logic [WIDTH-1:0] got; logic [CW-1:0] gch; bit ok; int y;
    @(posedge clk);
    #1;
    set_lane(1, 1024);
    in_valid[1] = 1'b1;
    wait_grant(rdy, ok);
    y = model_sample(1, 1024);
    n_checks++; if (rdy !== 4'b0010) $display("FAIL cfg_ready got=%b want=0010", rdy); else n_pass++;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_wdata = 1024;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    m_sh[0] = 1024;
    wait_out('0, lat, ok);
    n_checks++; if (out_data !== WIDTH'(y) || !ok) $display("FAIL cfg_old_coef got=%0d want=%0d", $signed(out_data), y); else n_pass++;
    $display("cfg: ch=1 x=1024 y=%0d exp=%0d", $signed(out_data), y);
    accept();
    run_one(3, 1024, rdy, lat, got, gch, ok);
    y = model_sample(3, 1024);
    n_checks++; if (got !== WIDTH'(y) || !ok) $display("FAIL cfg_new_coef got=%0d want=%0d", $signed(got), y); else n_pass++;
    n_checks++; if (gch !== 2'd3) $display("FAIL cfg_chan got=%0d want=3", gch); else n_pass++;
    $display("cfg: ch=3 x=1024 y=%0d exp=%0d", $signed(got), y);
    accept();
  endtask

  task automatic test_back_to_back();
    logic [NCH-1:0] rdy; logic [NCH-1:0] exp_oh; int lat; bit ok; int y; int x; int ec; int coef;
    for (int a = 0; a < 4; a++) begin
      coef = int'($urandom_range(0, 4095)) - 2048;
      @(posedge clk);
      #1;
      cfg_we = 1'b1;
      cfg_addr = a[1:0];
      cfg_wdata = coef;
      m_sh[a] = coef;
    end
    @(posedge clk);
    #1 cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) set_lane(c, int'($urandom));
    in_valid = '1;
    for (int k = 0; k < 3*NCH; k++) begin
      ec = m_rr;
      exp_oh = '0;
      exp_oh[ec] = 1'b1;
      wait_grant(rdy, ok);
      n_checks++; if (rdy !== exp_oh || !ok) $display("FAIL rr_grant k=%0d got=%b want=%b", k, rdy, exp_oh); else n_pass++;
      x = int'(in_data[ec*WIDTH +: WIDTH]);
      y = model_sample(ec, x);
      wait_out('0, lat, ok);
      n_checks++; if (lat !== 5 || !ok) $display("FAIL rr_latency k=%0d got=%0d want=5", k, lat); else n_pass++;
      n_checks++; if (out_data !== WIDTH'(y)) $display("FAIL rr_data k=%0d got=%0d want=%0d", k, $signed(out_data), y); else n_pass++;
      n_checks++; if (out_chan !== ec[CW-1:0]) $display("FAIL rr_chan k=%0d got=%0d want=%0d", k, out_chan, ec); else n_pass++;
      $display("rr: k=%0d ch=%0d x=%0d y=%0d exp=%0d", k, ec, x, $signed(out_data), y);
      set_lane(ec, int'($urandom));
      if (k == 3*NCH-1) in_valid = '0;
      accept();
    end
  endtask

  task automatic test_reset_midflight();
    logic [NCH-1:0] rdy; int lat; logic [WIDTH-1:0] got; logic [CW-1:0] gch; bit ok; int y;
    @(posedge clk);
    #1;
    set_lane(1, 12345);
    in_valid[1] = 1'b1;
    wait_grant(rdy, ok);
    n_checks++; if (!ok) $display("FAIL rst_mid_grant got=timeout want=grant"); else n_pass++;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    in_valid[2] = 1'b1;
    set_lane(2, 99);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before got=%b want=1", busy); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (in_ready !== '0) $display("FAIL rst_mid_in_ready got=%b want=0", in_ready); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_mid_data got=%0d want=0", out_data); else n_pass++;
    @(posedge clk);
    #1 in_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    run_one(0, 1024, rdy, lat, got, gch, ok);
    y = model_sample(0, 1024);
    n_checks++; if (rdy !== 4'b0001) $display("FAIL rst_after_ready got=%b want=0001", rdy); else n_pass++;
    n_checks++; if (lat !== 5) $display("FAIL rst_after_latency got=%0d want=5", lat); else n_pass++;
    n_checks++; if (got !== WIDTH'(y) || !ok) $display("FAIL rst_after_data got=%0d want=%0d", $signed(got), y); else n_pass++;
    n_checks++; if (gch !== 2'd0) $display("FAIL rst_after_chan got=%0d want=0", gch); else n_pass++;
    $display("reset_mid: ch=0 x=1024 y=%0d exp=%0d", $signed(got), y);
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_backpressure();
    test_cfg_midflight();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
